// File: rtl/bin_string_sender.sv
`default_nettype none
// ============================================================================
// Module   : bin_string_sender
// Purpose  : Prints one byte as an ASCII binary string, one '0'/'1' character
//            per bit, over the UART transmit handshake
//            (tx_data / new_tx_data / tx_busy). A byte producer hands bytes
//            over with in_valid/in_ready.
// Options  : BIN_SENDER_CRLF_EN (macro) - when defined, each string is
//            terminated by CR (8'h0D) and LF (8'h0A), giving 10 characters
//            per byte instead of 8.
// Params   : MSB_FIRST  1: bit 7 printed first, 0: bit 0 printed first
//            CHAR_ZERO  character printed for a 0 bit
//            CHAR_ONE   character printed for a 1 bit
// Ports    : clk          clock, everything on the rising edge
//            rst_n        asynchronous active-low reset
//            in_data      byte to print, captured on the accept edge
//            in_valid     producer has a byte
//            in_ready     idle and able to accept a byte (combinational)
//            tx_data      character to the UART transmitter (registered)
//            new_tx_data  one-cycle strobe qualifying tx_data (registered)
//            tx_busy      UART transmitter busy
// Revision : 1.0 - initial release
// ============================================================================
module bin_string_sender #(
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [7:0] CHAR_ZERO = 8'h30,
  parameter logic [7:0] CHAR_ONE  = 8'h31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy
);

`ifdef BIN_SENDER_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        new_q, new_d;

  logic [2:0]  bit_sel;
  logic [7:0]  cur_char;

  // Character for the current index: a data bit, or the CR/LF terminator.
  always_comb begin
    bit_sel  = MSB_FIRST ? (3'd7 - idx_q[2:0]) : idx_q[2:0];
    cur_char = shift_q[bit_sel] ? CHAR_ONE : CHAR_ZERO;
`ifdef BIN_SENDER_CRLF_EN
    if (idx_q[3]) begin
      cur_char = idx_q[0] ? CHAR_LF : CHAR_CR;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_data_d = tx_data_q;
    new_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_d = cur_char;
          new_d     = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        // The transmitter only raises busy one cycle after the strobe, so
        // busy is not looked at here; this cycle just spaces the strobes.
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      shift_q   <= 8'h00;
      tx_data_q <= 8'h00;
      new_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
      new_q     <= new_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_string_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_string_sender
// Purpose  : Self-checking bench for bin_string_sender. Two instances share
//            all inputs, one printing MSB first and one LSB first. A queue
//            based reference model predicts in_ready, strobes and characters
//            every cycle; a vector table checks whole strings and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_string_sender;

`ifdef BIN_SENDER_CRLF_EN
  localparam int N = 10;
`else
  localparam int N = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       rdy_m, rdy_l, new_m, new_l;
  logic [7:0] txd_m, txd_l;

  bin_string_sender #(.MSB_FIRST(1'b1), .CHAR_ZERO(8'h30), .CHAR_ONE(8'h31)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .tx_data(txd_m), .new_tx_data(new_m), .tx_busy(tx_busy));

  bin_string_sender #(.MSB_FIRST(1'b0), .CHAR_ZERO(8'h30), .CHAR_ONE(8'h31)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .tx_data(txd_l), .new_tx_data(new_l), .tx_busy(tx_busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending characters per instance plus a spacing flag.
  logic [7:0] qm[$];
  logic [7:0] ql[$];
  bit         gap = 1'b0;
  logic [7:0] last_m = 8'h00, last_l = 8'h00;
  bit         exp_strobe = 1'b0, exp_acc = 1'b0, exp_ready = 1'b1;
  int         busy_mode = 0, busy_left = 0;

  typedef struct {
    logic [7:0]  d;
    logic [63:0] sm;   // expected string, MSB-first instance
    logic [63:0] sl;   // expected string, LSB-first instance
    int          busy; // 0 idle, 1 five-cycle busy after each strobe, 2 random
  } vec_t;
  vec_t tbl[9];

  function automatic logic [7:0] ch(input logic [7:0] d, input int i, input bit msb);
    logic b;
    if (i == 8) return 8'h0D;
    if (i == 9) return 8'h0A;
    b = msb ? d[7-i] : d[i];
    return b ? 8'h31 : 8'h30;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    exp_strobe = 1'b0;
    exp_acc    = 1'b0;
    if (!rst_n) begin
      qm.delete(); ql.delete();
      gap = 1'b0; last_m = 8'h00; last_l = 8'h00;
    end else if (gap) begin
      gap = 1'b0;
    end else if (qm.size() > 0) begin
      if (!tx_busy) begin
        last_m = qm.pop_front();
        last_l = ql.pop_front();
        exp_strobe = 1'b1;
        gap = 1'b1;
      end
    end else if (in_valid) begin
      for (int i = 0; i < N; i++) begin
        qm.push_back(ch(in_data, i, 1'b1));
        ql.push_back(ch(in_data, i, 1'b0));
      end
      exp_acc = 1'b1;
    end
    exp_ready = (qm.size() == 0) && !gap;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("in_ready_m", 80'(rdy_m), 80'(exp_ready));
    check("in_ready_l", 80'(rdy_l), 80'(exp_ready));
    check("strobe_m", 80'(new_m), 80'(exp_strobe));
    check("strobe_l", 80'(new_l), 80'(exp_strobe));
    check("tx_data_m", 80'(txd_m), 80'(last_m));
    check("tx_data_l", 80'(txd_l), 80'(last_l));
    if (exp_strobe) busy_left = 5;
    case (busy_mode)
      1: begin
        tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
      2: tx_busy = 1'($urandom_range(0, 1));
      default: tx_busy = 1'b0;
    endcase
  endtask

  // Hold in_valid until the model sees the accept; flags a timeout otherwise.
  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      got = exp_acc;
    end
    if (!got) check("accept_timeout", 80'd0, 80'd1);
  endtask

  task automatic send_byte(input vec_t v);
    logic [79:0] cap_m, cap_l, exp_m, exp_l;
    int nstr, lat;
    bit done;
    busy_mode = v.busy;
    in_data   = v.d;
    in_valid  = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    cap_m = '0; cap_l = '0; nstr = 0; lat = 0; done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      step();
      lat++;
      if (new_m) begin cap_m = {cap_m[71:0], txd_m}; nstr++; end
      if (new_l) cap_l = {cap_l[71:0], txd_l};
      done = rdy_m;
    end
`ifdef BIN_SENDER_CRLF_EN
    exp_m = {v.sm, 16'h0D0A};
    exp_l = {v.sl, 16'h0D0A};
`else
    exp_m = {16'h0000, v.sm};
    exp_l = {16'h0000, v.sl};
`endif
    check("string_msb", cap_m, exp_m);
    check("string_lsb", cap_l, exp_l);
    check("strobe_count", 80'(nstr), 80'(N));
    if (v.busy == 0) check("ready_latency", 80'(lat), 80'(2 * N));
    busy_mode = 0;
    tx_busy   = 1'b0;
  endtask

  initial begin
    int k, n30, n31, nstr;
    bit done;

    tbl[0] = '{8'hA5, "10100101", "10100101", 0};
    tbl[1] = '{8'h01, "00000001", "10000000", 0};
    tbl[2] = '{8'h3C, "00111100", "00111100", 1};
    tbl[3] = '{8'h55, "01010101", "10101010", 0};
    tbl[4] = '{8'hC6, "11000110", "01100011", 2};
    tbl[5] = '{8'h81, "10000001", "10000001", 0};
    tbl[6] = '{8'hF0, "11110000", "00001111", 1};
    tbl[7] = '{8'h00, "00000000", "00000000", 0};
    tbl[8] = '{8'hFF, "11111111", "11111111", 2};

    // Reset values while rst_n is held low.
    #1;
    check("reset_ready", 80'(rdy_m), 80'd1);
    check("reset_tx_data", 80'(txd_m), 80'h00);
    check("reset_strobe", 80'(new_m), 80'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    step();
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Table-driven strings.
    for (int i = 0; i < 9; i++) send_byte(tbl[i]);

    // Back-to-back: 00 then FF with in_valid held throughout.
    in_data  = 8'h00;
    in_valid = 1'b1;
    wait_accept();
    in_data = 8'hFF;
    k = 0; n30 = 0; n31 = 0; nstr = 0; done = 1'b0;
    for (int j = 0; j < 100 && !done; j++) begin
      done = rdy_m;   // accepted at the coming edge
      step();
      k++;
      if (new_m) begin
        nstr++;
        if (txd_m == 8'h30) n30++;
        if (txd_m == 8'h31) n31++;
      end
    end
    check("b2b_second_accept", 80'(k), 80'(2 * N + 1));
    in_valid = 1'b0;
    done = 1'b0;
    for (int j = 0; j < 100 && !done; j++) begin
      step();
      if (new_m) begin
        nstr++;
        if (txd_m == 8'h30) n30++;
        if (txd_m == 8'h31) n31++;
      end
      done = rdy_m;
    end
    check("b2b_strobes", 80'(nstr), 80'(2 * N));
    check("b2b_zeros", 80'(n30), 80'd8);
    check("b2b_ones", 80'(n31), 80'd8);

    // Reset after the third strobe of F0, then a full 81.
    in_data  = 8'hF0;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    nstr = 0;
    for (int j = 0; j < 100 && nstr < 3; j++) begin
      step();
      if (new_m) nstr++;
    end
    check("abort_third_strobe", 80'(nstr), 80'd3);
    rst_n = 1'b0;
    #1;
    check("abort_tx_data", 80'(txd_m), 80'h00);
    check("abort_strobe", 80'(new_m), 80'd0);
    check("abort_ready", 80'(rdy_m), 80'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    send_byte(tbl[5]);

    // Random traffic against the model, with occasional resets.
    busy_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      if (!in_valid && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end else if (in_valid && ($urandom_range(0, 7) == 0)) begin
        in_data = 8'($urandom);
      end
      step();
      if (exp_acc) in_valid = 1'b0;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    in_valid  = 1'b0;
    busy_mode = 0;
    done = 1'b0;
    for (int j = 0; j < 100 && !done; j++) begin
      step();
      done = exp_ready;
    end
    check("final_idle", 80'(rdy_m), 80'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
